firebird7_sib_multi_seg: RTL and testbench

- Multi-segment Segment Insertion Bit (SIB) for the IJTAG network.
- Generalises the single-bit SIB to NUM_SEG independently openable child segments. Each segment has its own SIB bit, update latch, select output and scan-in tap.
- Sits between a parent IJTAG path and up to NUM_SEG instrument chains (EDT, extest, BIST controllers). Replaces a cascade of single-bit SIBs with one block, with a programmable capture mode.

---
 rtl/firebird7_sib_multi_seg.sv | 131 +++++++++++++
 tb/tb_firebird7_sib_multi_seg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/firebird7_sib_multi_seg.sv
// Multi-segment SIB: NUM_SEG independently openable child segments behind one IJTAG hop.
// Optional build macro FIREBIRD7_SIB_SEG_LOCK_EN adds a static seg_lock input that keeps segments closed.

module firebird7_sib_seg_cell #(
    parameter logic RESET_BIT    = 1'b0,
    parameter bit   CAP_READBACK = 1'b0
) (
    input  logic ijtag_tck,
    input  logic ijtag_reset,
    input  logic capture_en,
    input  logic shift_en,
    input  logic update_en,
    input  logic lock,
    input  logic to_si,
    input  logic from_so,
    output logic sib,
    output logic latch,
    output logic to_enable
);
    logic stage_in;

    // A closed segment is bypassed: the SIB bit takes its own tap directly.
    assign stage_in = latch ? from_so : to_si;

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sib <= RESET_BIT;
        end else if (capture_en) begin
            sib <= CAP_READBACK ? latch : 1'b0;
        end else if (shift_en) begin
            sib <= stage_in;
        end
    end

    // to_enable lags latch by one negedge so the child select settles after update.
    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            latch     <= RESET_BIT;
            to_enable <= RESET_BIT;
        end else begin
            if (update_en) begin
                latch <= sib & ~lock;
            end
            to_enable <= latch;
        end
    end
endmodule

module firebird7_sib_multi_seg #(
    parameter int                 NUM_SEG      = 2,
    parameter logic [NUM_SEG-1:0] RESET_VAL    = '0,
    parameter int                 CAPTURE_MODE = 0
) (
    input  logic               ijtag_tck,
    input  logic               ijtag_reset,
    input  logic               ijtag_sel,
    input  logic               ijtag_si,
    input  logic               ijtag_ce,
    input  logic               ijtag_se,
    input  logic               ijtag_ue,
`ifdef FIREBIRD7_SIB_SEG_LOCK_EN
    input  logic [NUM_SEG-1:0] seg_lock,
`endif
    output logic               ijtag_so,
    input  logic [NUM_SEG-1:0] ijtag_from_so,
    output logic [NUM_SEG-1:0] ijtag_to_si,
    output logic [NUM_SEG-1:0] ijtag_to_sel
);
    localparam bit CAP_RB = (CAPTURE_MODE != 0);

    logic [NUM_SEG-1:0] sib;
    logic [NUM_SEG-1:0] latch;
    logic [NUM_SEG-1:0] to_enable;
    logic [NUM_SEG-1:0] lock_mask;
    logic               capture_en;
    logic               shift_en;
    logic               update_en;
    logic               so_q;

`ifdef FIREBIRD7_SIB_SEG_LOCK_EN
    assign lock_mask = seg_lock;
`else
    assign lock_mask = '0;
`endif

    // Capture has priority over shift when both enables are high.
    assign capture_en = ijtag_ce & ijtag_sel;
    assign shift_en   = ijtag_se & ijtag_sel & ~ijtag_ce;
    assign update_en  = ijtag_ue & ijtag_sel;

    genvar i;
    generate
        for (i = 0; i < NUM_SEG; i++) begin : g_seg
            if (i == 0) begin : g_head
                assign ijtag_to_si[i] = ijtag_si;
            end else begin : g_tail
                assign ijtag_to_si[i] = sib[i-1];
            end

            firebird7_sib_seg_cell #(
                .RESET_BIT    (RESET_VAL[i]),
                .CAP_READBACK (CAP_RB)
            ) u_cell (
                .ijtag_tck   (ijtag_tck),
                .ijtag_reset (ijtag_reset),
                .capture_en  (capture_en),
                .shift_en    (shift_en),
                .update_en   (update_en),
                .lock        (lock_mask[i]),
                .to_si       (ijtag_to_si[i]),
                .from_so     (ijtag_from_so[i]),
                .sib         (sib[i]),
                .latch       (latch[i]),
                .to_enable   (to_enable[i])
            );
        end
    endgenerate

    assign ijtag_to_sel = to_enable & {NUM_SEG{ijtag_sel}};

    // Negative-level retiming latch gives the parent a half-cycle of hold on so.
    always_latch begin
        if (!ijtag_reset) begin
            so_q <= RESET_VAL[NUM_SEG-1];
        end else if (!ijtag_tck) begin
            so_q <= sib[NUM_SEG-1];
        end
    end

    assign ijtag_so = so_q;
endmodule

// File: tb/tb_firebird7_sib_multi_seg.sv
// Directed bench for firebird7_sib_multi_seg: three NUM_SEG=3 instances with different
// reset/capture settings, each selected in turn so the others hold.

module tb_firebird7_sib_multi_seg;
    logic       tck = 1'b0;
    logic       rst, si, ce, se, ue, s0, s1, s2, c2;
    logic [1:0] c1 = 2'b00;
    logic [2:0] u0_from_so, u0_to_si, u0_to_sel;
    logic [2:0] u1_from_so, u1_to_si, u1_to_sel;
    logic [2:0] u2_from_so, u2_to_si, u2_to_sel;
    logic       u0_so, u1_so, u2_so;
    int         checks = 0;
    int         errors = 0;

`ifdef FIREBIRD7_SIB_SEG_LOCK_EN
    localparam logic [2:0] EXP_LOCK_SEL = 3'b110;
`else
    localparam logic [2:0] EXP_LOCK_SEL = 3'b111;
`endif

    always #10 tck = ~tck;

    // Child 1 of u0: a 2-bit instrument chain shifting while selected.
    always @(posedge tck)
        if (s0 && se && !ce && u0_to_sel[1]) c1 <= {c1[0], u0_to_si[1]};

    assign u0_from_so = {1'b0, c1[1], 1'b0};
    assign u1_from_so = u1_to_si;           // zero-length children
    assign u2_from_so = {c2, 2'b00};

    firebird7_sib_multi_seg #(.NUM_SEG(3), .RESET_VAL(3'b000), .CAPTURE_MODE(0)) u0 (
        .ijtag_tck(tck), .ijtag_reset(rst), .ijtag_sel(s0), .ijtag_si(si),
        .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue),
`ifdef FIREBIRD7_SIB_SEG_LOCK_EN
        .seg_lock(3'b000),
`endif
        .ijtag_so(u0_so), .ijtag_from_so(u0_from_so), .ijtag_to_si(u0_to_si),
        .ijtag_to_sel(u0_to_sel));

    firebird7_sib_multi_seg #(.NUM_SEG(3), .RESET_VAL(3'b000), .CAPTURE_MODE(1)) u1 (
        .ijtag_tck(tck), .ijtag_reset(rst), .ijtag_sel(s1), .ijtag_si(si),
        .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue),
`ifdef FIREBIRD7_SIB_SEG_LOCK_EN
        .seg_lock(3'b000),
`endif
        .ijtag_so(u1_so), .ijtag_from_so(u1_from_so), .ijtag_to_si(u1_to_si),
        .ijtag_to_sel(u1_to_sel));

    firebird7_sib_multi_seg #(.NUM_SEG(3), .RESET_VAL(3'b100), .CAPTURE_MODE(0)) u2 (
        .ijtag_tck(tck), .ijtag_reset(rst), .ijtag_sel(s2), .ijtag_si(si),
        .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue),
`ifdef FIREBIRD7_SIB_SEG_LOCK_EN
        .seg_lock(3'b001),
`endif
        .ijtag_so(u2_so), .ijtag_from_so(u2_from_so), .ijtag_to_si(u2_to_si),
        .ijtag_to_sel(u2_to_sel));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: posedge (shift/capture) then negedge (update), sampled 1 after the negedge.
    task automatic step(input logic i_si, input logic i_ce, input logic i_se, input logic i_ue);
        si = i_si; ce = i_ce; se = i_se; ue = i_ue;
        @(negedge tck);
        #1;
    endtask

    initial begin
        rst = 1'b0; s0 = 1'b1; s1 = 1'b1; s2 = 1'b1;
        si = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; c2 = 1'b0;
        @(negedge tck);
        #1;
        chk("rst_u0_so",    u0_so,     8'd0);
        chk("rst_u0_to_si", u0_to_si,  8'd0);
        chk("rst_u0_tosel", u0_to_sel, 8'd0);
        chk("rst_u2_tosel", u2_to_sel, 8'h4);
        chk("rst_u2_so",    u2_so,     8'd1);
        rst = 1'b1; s1 = 1'b0; s2 = 1'b0;

        // u0: shift, then reset pulse in the middle of a shift cycle
        step(1, 0, 1, 0);
        chk("shift1_to_si", u0_to_si, 8'h3);
        step(1, 0, 1, 0);
        si = 1'b1; se = 1'b1;
        @(posedge tck);
        #5 rst = 1'b0;
        #1;
        chk("midrst_to_si", u0_to_si,  8'h1);
        chk("midrst_so",    u0_so,     8'd0);
        chk("midrst_tosel", u0_to_sel, 8'd0);
        @(negedge tck);
        #1 rst = 1'b1;

        // all closed: path length 3
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("len3_b2", u0_so, 8'd0);
        step(0, 0, 1, 0);
        chk("len3_b3", u0_so, 8'd1);

        // load 010, update, select child 1 one negedge later
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("load010_to_si", u0_to_si, 8'h4);
        step(0, 0, 0, 1);
        chk("upd_tosel_n0", u0_to_sel, 8'd0);
        step(0, 0, 0, 0);
        chk("upd_tosel_n1", u0_to_sel, 8'h2);

        // child 1 (2 bits) now in the path: length 5
        step(1, 0, 1, 0);
        chk("open_to_si1", u0_to_si, 8'h3);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("len5_b3", u0_so, 8'd0);
        step(0, 0, 1, 0);
        chk("len5_b4", u0_so, 8'd0);
        step(0, 0, 1, 0);
        chk("len5_b5", u0_so, 8'd1);

        // ce and se together: capture wins
        step(1, 1, 1, 0);
        chk("cese_to_si", u0_to_si, 8'h1);
        chk("cese_so",    u0_so,    8'd0);

        // deselected: no shift, no update, to_sel forced low
        s0 = 1'b0;
        step(1, 0, 1, 1);
        chk("nosel_tosel", u0_to_sel, 8'd0);
        chk("nosel_to_si", u0_to_si,  8'h1);
        s0 = 1'b1;
        step(0, 0, 0, 0);
        chk("nosel_latch_kept", u0_to_sel, 8'h2);

        // CAPTURE_MODE=0: capture loads zeros
        step(1, 0, 1, 0);
        chk("cm0_pre_to_si", u0_to_si, 8'h3);
        step(0, 1, 0, 0);
        chk("cm0_cap_to_si", u0_to_si, 8'd0);
        chk("cm0_cap_so",    u0_so,    8'd0);

        // u1, CAPTURE_MODE=1: latch 101 is read back through capture
        s0 = 1'b0; s1 = 1'b1;
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        chk("cm1_load_so", u1_so, 8'd1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("cm1_cleared_so", u1_so, 8'd0);
        step(0, 1, 0, 0);
        chk("cm1_cap_b0", u1_so,     8'd1);
        chk("cm1_tosel",  u1_to_sel, 8'h5);
        step(0, 0, 1, 0);
        chk("cm1_cap_b1", u1_so, 8'd0);
        step(0, 0, 1, 0);
        chk("cm1_cap_b2", u1_so, 8'd1);

        // u2, RESET_VAL=100: child 2 open out of reset, retiming alignment
        s1 = 1'b0; s2 = 1'b1;
        #1;
        chk("rv_tosel", u2_to_sel, 8'h4);
        c2 = 1'b0; si = 1'b0; se = 1'b1; ce = 1'b0; ue = 1'b0;
        @(posedge tck);
        #1;
        chk("rt_hold0", u2_so, 8'd1);
        @(negedge tck);
        #1;
        chk("rt_pass0", u2_so, 8'd0);
        c2 = 1'b1;
        @(posedge tck);
        #1;
        chk("rt_hold1", u2_so, 8'd0);
        @(negedge tck);
        #1;
        chk("rt_pass1", u2_so, 8'd1);

        // shift 111 and update; segment 0 stays closed when locked
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("lock_tosel", u2_to_sel, {5'd0, EXP_LOCK_SEL});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
